display_scanner: RTL and testbench
==================================

// Module: display_scanner
// PURPOSE
//  Time-multiplexes a 16-bit value (4 hex digits) onto a 4-digit common-anode 7-seg display.
//  Each refresh slot drives one active-low anode. The slot's nibble goes out on digit_out,
//  which connects directly to the nibble input of the downstream seven-segment decoder.
//  Display value is double-buffered and only swaps at a frame boundary, so digits never tear.
//  Optional leading-zero blanking and an anti-ghosting blank gap between slots.
// PARAMETERS
//  REFRESH_DIV  100000  clock cycles per digit slot; must be >= BLANK_GAP+2
//  BLANK_GAP    16      cycles at start of each slot with all anodes off (0 = no gap)
// PORTS
//  clk        in   1   system clock, all logic on rising edge
//  reset      in   1   synchronous, active-low reset
//  value      in   16  new display value; [3:0] = digit 0 (rightmost)
//  load       in   1   1-cycle strobe: capture value into pending buffer
//  lzb        in   1   1 = blank leading zero digits (digit 0 never blanked)
//  digit_out  out  4   nibble of current slot, to decoder input
//  an         out  4   anode enables, active-low, an[i] = digit i
//  frame_done out  1   1-cycle pulse at start of each new frame
// BEHAVIOUR
//  State registers: div_cnt (0..REFRESH_DIV-1), idx (0..3), disp[15:0], pend[15:0], pend_v.
//  - Reset (reset==0 at clk edge): div_cnt=0, idx=0, disp=0, pend=0, pend_v=0,
//    an=4'b1111, digit_out=0, frame_done=0. Reset overrides load and any in-progress slot.
//  - div_cnt increments every cycle. At REFRESH_DIV-1 it wraps to 0, and idx increments (3 wraps to 0).
//  - Boundary cycle is the cycle where div_cnt==REFRESH_DIV-1 and idx==3.
//  - frame_done is registered. It is 1 exactly in the cycle after the boundary,
//    i.e. the cycle with idx==0 and div_cnt==0.
//  - digit_out = disp[4*idx+3:4*idx], valid for the whole slot including the gap.
//  - an: all 1 when div_cnt < BLANK_GAP. Otherwise an[idx]=0 and the others stay 1,
//    unless digit idx is blanked.
//  - Leading-zero blanking (lzb==1): digit i (i>=1) is blanked if disp nibbles i..3 are all zero.
//    A blanked digit keeps an=4'b1111 for its whole slot. lzb is sampled live each cycle.
//  - load in a non-boundary cycle: pend<=value, pend_v<=1. Last load in a frame wins.
//  - Boundary cycle, no load: if pend_v, then disp<=pend and pend_v<=0. Otherwise disp is unchanged.
//  - Boundary cycle with load: disp<=value (bypass) and pend_v<=0.
//  - Latency: a load lands on screen at the next frame start, at most 4*REFRESH_DIV cycles later.
//  - an and digit_out are derived from registered state only. No glitch paths from value or load.
// TESTING (REFRESH_DIV=8, BLANK_GAP=2)
//  1. reset low 3 cycles -> an=1111, digit_out=0, frame_done=0. Release ->
//     an=1111 for 2 cycles, an=1110 for 6 cycles, then an=1111 x2, an=1101 x6, ...
//  2. load 16'h1234 mid-frame -> digits stay 0 until frame_done. Then slot0..3 digit_out =
//     4,3,2,1 with an=1110,1101,1011,0111.
//  3. load 16'hAAAA, then 16'h00F0 in the same frame -> next frame shows 0,F,0,0 only.
//     16'hAAAA never appears.
//  4. lzb=1: value 16'h0005 -> only an=1110 ever asserted, digit 5. 16'h0000 -> only digit0 shows 0.
//     16'h0100 -> digit3 blanked; digits 2,1,0 shown as 1,0,0.
//  5. load 16'hBEEF exactly on the boundary cycle -> the frame starting next cycle shows F,E,E,B.
//  6. load 16'h5555, then reset low mid-frame before the boundary -> after release disp=0.
//     Pending is discarded and 5 never shows.

Source files
------------

// File: rtl/display_scanner.sv
// Scans a double-buffered 16-bit value across a 4-digit common-anode display.
// Optional leading-zero blanking and a blank gap between slots to prevent ghosting.
module display_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_GAP   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        lzb,
  output logic [3:0]  digit_out,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] div_cnt_reg;
  logic [1:0]    idx_reg;
  logic [15:0]   disp_reg;
  logic [15:0]   pend_reg;
  logic          pend_v_reg;
  logic          frame_done_reg;
  logic          hold_reg;
  logic          boundary;
  logic          in_gap;
  logic [3:0]    blank;

  assign boundary = (div_cnt_reg == LAST) && (idx_reg == 2'd3);

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt_reg    <= '0;
      idx_reg        <= 2'd0;
      disp_reg       <= 16'h0000;
      pend_reg       <= 16'h0000;
      pend_v_reg     <= 1'b0;
      frame_done_reg <= 1'b0;
      hold_reg       <= 1'b1;
    end else begin
      hold_reg       <= 1'b0;
      frame_done_reg <= boundary;
      if (div_cnt_reg == LAST) begin
        div_cnt_reg <= '0;
        idx_reg     <= idx_reg + 2'd1;
      end else begin
        div_cnt_reg <= div_cnt_reg + CW'(1);
      end
      // A load on the boundary itself goes straight to the display
      if (boundary) begin
        pend_v_reg <= 1'b0;
        if (load) begin
          disp_reg <= value;
        end else if (pend_v_reg) begin
          disp_reg <= pend_reg;
        end
      end else if (load) begin
        pend_reg   <= value;
        pend_v_reg <= 1'b1;
      end
    end
  end

  generate
    if (BLANK_GAP == 0) begin : g_no_gap
      assign in_gap = 1'b0;
    end else begin : g_gap
      localparam logic [CW-1:0] GAP = CW'(BLANK_GAP);
      assign in_gap = (div_cnt_reg < GAP);
    end
  endgenerate

  // Digit i is a leading zero when nibbles i..3 are all zero; digit 0 always shows
  assign blank[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_blank
      assign blank[gi] = lzb && (disp_reg[15:4*gi] == '0);
    end
  endgenerate

  assign digit_out  = disp_reg[{idx_reg, 2'b00} +: 4];
  assign frame_done = frame_done_reg;

  // hold_reg keeps anodes dark while in reset even when there is no gap
  always_comb begin
    an = 4'b1111;
    if (!hold_reg && !in_gap && !blank[idx_reg]) begin
      an[idx_reg] = 1'b0;
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner: expected slots are queued per frame and
// compared cycle by cycle while the frame is scanned.
module tb_display_scanner;

  localparam int RDIV = 8;
  localparam int GAP  = 2;
  localparam int FRAME = 4 * RDIV;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] dig;
  } slot_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] value = 16'h0000;
  logic        load = 1'b0;
  logic        lzb = 1'b0;
  logic [3:0]  digit_out;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int failures = 0;
  slot_t exp_q[$];

  display_scanner #(.REFRESH_DIV(RDIV), .BLANK_GAP(GAP)) dut (
    .clk(clk),
    .reset(reset),
    .value(value),
    .load(load),
    .lzb(lzb),
    .digit_out(digit_out),
    .an(an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected appearance of one frame for a given display value and blanking mode
  task automatic push_frame(input logic [15:0] v, input bit blank_en);
    slot_t s;
    logic [15:0] upper;
    for (int i = 0; i < 4; i++) begin
      upper = v >> (4 * i);
      s.dig = 4'((v >> (4 * i)) & 16'hF);
      if (blank_en && i >= 1 && upper == 16'h0000) s.an = 4'b1111;
      else s.an = ~(4'b0001 << i);
      exp_q.push_back(s);
    end
  endtask

  // Checks 'stop' cycles starting at a frame-start cycle; optional loads at cycles la/lb
  task automatic run_frame(input string name, input bit fd_first,
                           input int la, input logic [15:0] va,
                           input int lb, input logic [15:0] vb,
                           input int stop);
    slot_t cur;
    logic [3:0] exp_an;
    logic exp_fd;
    int nerr;
    nerr = 0;
    cur = '0;
    for (int k = 0; k < stop; k++) begin
      if (k % RDIV == 0) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          nerr++;
          $display("FAIL %s scoreboard empty at k=%0d", name, k);
        end else begin
          cur = exp_q.pop_front();
        end
      end
      exp_an = (k % RDIV < GAP) ? 4'b1111 : cur.an;
      exp_fd = (k == 0) && fd_first;
      checks++;
      if (an !== exp_an) begin
        failures++; nerr++;
        $display("FAIL %s an k=%0d got %b expected %b", name, k, an, exp_an);
      end
      checks++;
      if (digit_out !== cur.dig) begin
        failures++; nerr++;
        $display("FAIL %s digit_out k=%0d got %h expected %h", name, k, digit_out, cur.dig);
      end
      checks++;
      if (frame_done !== exp_fd) begin
        failures++; nerr++;
        $display("FAIL %s frame_done k=%0d got %b expected %b", name, k, frame_done, exp_fd);
      end
      if (k == la) begin load = 1'b1; value = va; end
      if (k == lb) begin load = 1'b1; value = vb; end
      tick();
      load = 1'b0;
    end
    exp_q.delete();
    $display("frame %s: %0d cycles checked, %0d errors", name, stop, nerr);
  endtask

  task automatic check_reset_cycles(input string name, input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      checks++;
      if (an !== 4'b1111 || digit_out !== 4'h0 || frame_done !== 1'b0) begin
        failures++;
        $display("FAIL %s cycle %0d got an=%b dig=%h fd=%b expected an=1111 dig=0 fd=0",
                 name, i, an, digit_out, frame_done);
      end
    end
    reset = 1'b1;
    $display("reset %s: %0d cycles held", name, n);
  endtask

  task automatic test_reset();
    check_reset_cycles("reset", 3);
    push_frame(16'h0000, 1'b0);
    run_frame("after_reset", 1'b0, -1, 16'h0, -1, 16'h0, FRAME);
  endtask

  task automatic test_load_basic();
    push_frame(16'h0000, 1'b0);
    run_frame("load_1234_pending", 1'b1, 10, 16'h1234, -1, 16'h0, FRAME);
    push_frame(16'h1234, 1'b0);
    run_frame("show_1234", 1'b1, -1, 16'h0, -1, 16'h0, FRAME);
  endtask

  task automatic test_last_load_wins();
    push_frame(16'h0000, 1'b0);
    exp_q.delete();
    push_frame(16'h1234, 1'b0);
    run_frame("load_aaaa_00f0", 1'b1, 4, 16'hAAAA, 20, 16'h00F0, FRAME);
    push_frame(16'h00F0, 1'b0);
    run_frame("show_00f0", 1'b1, 6, 16'h0005, -1, 16'h0, FRAME);
  endtask

  task automatic test_lzb();
    lzb = 1'b1;
    push_frame(16'h0005, 1'b1);
    run_frame("lzb_0005", 1'b1, 9, 16'h0000, -1, 16'h0, FRAME);
    push_frame(16'h0000, 1'b1);
    run_frame("lzb_0000", 1'b1, 17, 16'h0100, -1, 16'h0, FRAME);
    push_frame(16'h0100, 1'b1);
    run_frame("lzb_0100", 1'b1, -1, 16'h0, -1, 16'h0, FRAME);
    lzb = 1'b0;
    push_frame(16'h0100, 1'b0);
    run_frame("nolzb_0100", 1'b1, -1, 16'h0, -1, 16'h0, FRAME);
  endtask

  task automatic test_boundary_load();
    push_frame(16'h0100, 1'b0);
    run_frame("boundary_beef", 1'b1, 5, 16'h1111, FRAME - 1, 16'hBEEF, FRAME);
    push_frame(16'hBEEF, 1'b0);
    run_frame("show_beef", 1'b1, -1, 16'h0, -1, 16'h0, FRAME);
  endtask

  task automatic test_reset_discards_pending();
    push_frame(16'hBEEF, 1'b0);
    run_frame("load_5555_then_reset", 1'b1, 3, 16'h5555, -1, 16'h0, 12);
    check_reset_cycles("midframe_reset", 3);
    push_frame(16'h0000, 1'b0);
    run_frame("post_reset_0", 1'b0, -1, 16'h0, -1, 16'h0, FRAME);
    push_frame(16'h0000, 1'b0);
    run_frame("post_reset_1", 1'b1, -1, 16'h0, -1, 16'h0, FRAME);
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_last_load_wins();
    test_lzb();
    test_boundary_load();
    test_reset_discards_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
